// File: rtl/spine_egress_buffer.sv
// Elastic first-word-fall-through buffer between a router spine output (no backpressure)
// and a spine switch input with valid/ready. It counts overflow drops and flags stalls.
module spine_egress_buffer #(
   parameter int unsigned DWIDTH      = 16,
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned STALL_LIMIT = 255
) (
   input  logic                     ACLK,
   input  logic                     ARESETn,
   input  logic [DWIDTH-1:0]        in_data,
   input  logic                     in_valid,
   output logic [DWIDTH-1:0]        out_data,
   output logic                     out_valid,
   output logic [5:0]               out_dest_addr,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     fifo_full,
   output logic                     fifo_empty,
   output logic [7:0]               drop_count,
   output logic                     stall_err,
   input  logic                     clr_status
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
   localparam logic [15:0]   STALL_MAX = 16'(STALL_LIMIT);

   logic [DWIDTH-1:0] mem_q [DEPTH];

   logic [AW-1:0] wr_ptr_q,    wr_ptr_d;
   logic [AW-1:0] rd_ptr_q,    rd_ptr_d;
   logic [CW-1:0] count_q,     count_d;
   logic [7:0]    drop_q,      drop_d;
   logic [15:0]   stall_cnt_q, stall_cnt_d;
   logic          stall_err_q, stall_err_d;

   logic empty;
   logic full;
   logic pop;
   logic push;
   logic drop;
   logic stalled;

   // Handshake decode and status outputs.
   always_comb begin
      empty   = (count_q == '0);
      full    = (count_q == FULL_CNT);
      pop     = !empty && out_ready;
      // A full FIFO still accepts a flit when the head leaves in the same cycle.
      push    = in_valid && (!full || pop);
      drop    = in_valid && full && !pop;
      stalled = !empty && !out_ready;
   end

   always_comb begin
      out_valid     = !empty;
      out_data      = empty ? '0 : mem_q[rd_ptr_q];
      out_dest_addr = out_data[15:10];
      fifo_count    = count_q;
      fifo_full     = full;
      fifo_empty    = empty;
      drop_count    = drop_q;
      stall_err     = stall_err_q;
   end

   // Next-state logic for pointers, occupancy, drop counter and stall monitor.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      drop_d      = drop_q;
      stall_cnt_d = '0;
      stall_err_d = stall_err_q;

      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);

      if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

      // The counter only runs while the head is held; a pop or an empty FIFO resets it.
      if (stalled) begin
         if (stall_cnt_q == STALL_MAX) begin
            stall_cnt_d = stall_cnt_q;
         end else begin
            stall_cnt_d = stall_cnt_q + 16'd1;
            if ((stall_cnt_q + 16'd1) == STALL_MAX) stall_err_d = 1'b1;
         end
      end

      if (clr_status) begin
         drop_d      = '0;
         stall_err_d = 1'b0;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         drop_q      <= '0;
         stall_cnt_q <= '0;
         stall_err_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         drop_q      <= drop_d;
         stall_cnt_q <= stall_cnt_d;
         stall_err_q <= stall_err_d;
      end
   end

   // NOTE: storage is deliberately not reset; stale entries are never visible since out_data is masked when empty.
   always_ff @(posedge ACLK) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
   end

endmodule

// File: tb/tb_spine_egress_buffer.sv
// Directed bench for spine_egress_buffer: stimulus queues expected flits in a scoreboard,
// a negedge monitor pops and compares every accepted output flit.
module tb_spine_egress_buffer;

   logic        ACLK = 1'b0;
   logic        ARESETn;
   logic [15:0] in_data;
   logic        in_valid;
   logic [15:0] out_data;
   logic        out_valid;
   logic [5:0]  out_dest_addr;
   logic        out_ready;
   logic [3:0]  fifo_count;
   logic        fifo_full;
   logic        fifo_empty;
   logic [7:0]  drop_count;
   logic        stall_err;
   logic        clr_status;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] sb[$];
   logic        prev_stall = 1'b0;
   logic [15:0] prev_data  = '0;

   spine_egress_buffer #(
      .DWIDTH      (16),
      .DEPTH       (8),
      .STALL_LIMIT (4)
   ) dut (
      .ACLK          (ACLK),
      .ARESETn       (ARESETn),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_dest_addr (out_dest_addr),
      .out_ready     (out_ready),
      .fifo_count    (fifo_count),
      .fifo_full     (fifo_full),
      .fifo_empty    (fifo_empty),
      .drop_count    (drop_count),
      .stall_err     (stall_err),
      .clr_status    (clr_status)
   );

   always #5 ACLK = ~ACLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle of stimulus; an accepted flit is queued as the expected output.
   task automatic cyc(input logic v, input logic [15:0] d, input logic r,
                      input logic acc, input logic clr);
      in_valid   = v;
      in_data    = d;
      out_ready  = r;
      clr_status = clr;
      if (v && acc) sb.push_back(d);
      @(posedge ACLK);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_out_valid"},  32'(out_valid),     32'd0);
      check({tag, "_out_data"},   32'(out_data),      32'd0);
      check({tag, "_dest"},       32'(out_dest_addr), 32'd0);
      check({tag, "_count"},      32'(fifo_count),    32'd0);
      check({tag, "_empty"},      32'(fifo_empty),    32'd1);
      check({tag, "_full"},       32'(fifo_full),     32'd0);
      check({tag, "_drop"},       32'(drop_count),    32'd0);
      check({tag, "_stall_err"},  32'(stall_err),     32'd0);
   endtask

   // Monitor: inputs are stable from posedge+1 to the next posedge, so a negedge sample
   // with out_valid && out_ready is exactly a pop at the coming edge.
   always @(negedge ACLK) begin
      if (!ARESETn) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && out_valid) check("hold_data", 32'(out_data), 32'(prev_data));
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_pop: got 0x%0h, expected no output at %0t", out_data, $time);
            end else begin
               logic [15:0] exp;
               exp = sb.pop_front();
               check("pop_data", 32'(out_data), 32'(exp));
               check("pop_dest", 32'(out_dest_addr), 32'(exp[15:10]));
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ARESETn    = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      out_ready  = 1'b0;
      clr_status = 1'b0;
      repeat (2) @(posedge ACLK);
      #1;
      check_reset_values("rst");
      ARESETn = 1'b1;

      // Pass-through: first push lands on the first edge after reset release.
      cyc(1'b1, 16'hA5C3, 1'b1, 1'b1, 1'b0);
      check("pt_valid", 32'(out_valid),     32'd1);
      check("pt_data",  32'(out_data),      32'hA5C3);
      check("pt_dest",  32'(out_dest_addr), 32'h29);
      cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      check("pt_empty", 32'(fifo_empty),    32'd1);
      check("pt_valid0", 32'(out_valid),    32'd0);

      // Fill and overflow: 10 pushes into 8 entries, no pops.
      for (int i = 1; i <= 10; i++) begin
         cyc(1'b1, 16'(i), 1'b0, (i <= 8), 1'b0);
         if (i == 1) check("fill_first_head", 32'(out_data), 32'h0001);
      end
      check("fill_full",  32'(fifo_full),  32'd1);
      check("fill_count", 32'(fifo_count), 32'd8);
      check("fill_drop",  32'(drop_count), 32'd2);
      check("fill_stall_err", 32'(stall_err), 32'd1);
      check("fill_head",  32'(out_data),   32'h0001);

      // Full with simultaneous push and pop: no drop, occupancy unchanged.
      cyc(1'b1, 16'h1234, 1'b1, 1'b1, 1'b0);
      check("fpp_count", 32'(fifo_count), 32'd8);
      check("fpp_drop",  32'(drop_count), 32'd2);
      check("fpp_head",  32'(out_data),   32'h0002);
      for (int i = 0; i < 8; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      check("drain_empty", 32'(fifo_empty), 32'd1);
      check("drain_sb",    32'(sb.size()),  32'd0);
      check("drain_err_sticky", 32'(stall_err), 32'd1);
      cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      check("clr_err",  32'(stall_err),  32'd0);
      check("clr_drop", 32'(drop_count), 32'd0);

      // Stall: error rises after exactly 4 consecutive stalled cycles.
      cyc(1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
         check("stall_data", 32'(out_data), 32'hBEEF);
         check("stall_err_k", 32'(stall_err), (k == 4) ? 32'd1 : 32'd0);
      end
      cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      check("stall_clr", 32'(stall_err), 32'd0);
      cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      check("stall_drained", 32'(fifo_empty), 32'd1);

      // Coincident drop and clear: the clear wins.
      for (int i = 0; i < 8; i++) cyc(1'b1, 16'hC000 + 16'(i), 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);
      check("drop_one", 32'(drop_count), 32'd1);
      cyc(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1);
      check("drop_clr", 32'(drop_count), 32'd0);

      // Saturation: 300 drops stop at 255; contents untouched.
      for (int i = 0; i < 300; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
      check("sat_drop",  32'(drop_count), 32'd255);
      check("sat_count", 32'(fifo_count), 32'd8);
      check("sat_head",  32'(out_data),   32'hC000);

      // Asynchronous reset mid-burst, checked before the next clock edge.
      in_valid = 1'b1;
      in_data  = 16'h7777;
      #3;
      ARESETn = 1'b0;
      #1;
      check_reset_values("async");
      sb.delete();
      @(posedge ACLK);
      #1;
      in_valid = 1'b0;
      ARESETn  = 1'b1;

      // Recovery after reset.
      cyc(1'b1, 16'h5555, 1'b0, 1'b1, 1'b0);
      check("post_valid", 32'(out_valid),     32'd1);
      check("post_dest",  32'(out_dest_addr), 32'h15);
      cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      check("post_empty", 32'(fifo_empty), 32'd1);
      check("post_sb",    32'(sb.size()),  32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
